sha256_word_accumulator: RTL and testbench



---
 rtl/sha256_word_accumulator.sv | 166 ++++++++++++++++
 tb/tb_sha256_word_accumulator.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_word_accumulator.sv
// ---------------------------------------------------------------------------
// sha256_word_accumulator
//
// Sequential multi-operand adder (modulo 2^WIDTH) for the SHA-256 datapath,
// typically used to form T1 = h + S1(e) + Ch(e,f,g) + K[t] + W[t].
// NOPS operand words are taken one per cycle over a valid/ready handshake.
// The final sum is then held until the downstream stage takes it.
//
// Handshake semantics: a transfer happens on a rising edge where both valid
// and ready are high. Ready never depends on valid. A producer holds
// valid/data until the transfer. OutValid stays high, with Sum stable, until
// OutReady is sampled high, Abort is asserted, or reset occurs.
//
// Parameters:
//   WIDTH  operand/sum width in bits (default 32)
//   NOPS   operands per sum, 2..16 (default 5)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   InValid    operand valid
//   InReady    block can accept an operand (low in DONE or while Abort)
//   Operand    operand word
//   Abort      synchronous flush of any partial or held sum
//   OutValid   Sum is valid
//   OutReady   downstream takes Sum
//   Sum        accumulated result (always drives the accumulator)
//   OpCount    operands accepted into the current sum
//   CarryCount discarded carry-outs of the current sum
//              (present only with SHA256_ACC_CARRY_COUNT_EN)
//
// Optional feature macro: SHA256_ACC_CARRY_COUNT_EN
// ---------------------------------------------------------------------------
module sha256_word_accumulator #(
    parameter int WIDTH = 32,
    parameter int NOPS  = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      InValid,
    output logic                      InReady,
    input  logic [WIDTH-1:0]          Operand,
    input  logic                      Abort,
    output logic                      OutValid,
    input  logic                      OutReady,
    output logic [WIDTH-1:0]          Sum,
    output logic [$clog2(NOPS+1)-1:0] OpCount
`ifdef SHA256_ACC_CARRY_COUNT_EN
    ,
    output logic [$clog2(NOPS)-1:0]   CarryCount
`endif
);

    localparam int CW = $clog2(NOPS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] acc, acc_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic             accept;

    // Ripple chain of full-adder cells: word result plus final carry-out.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] add_sum;

    always_comb begin
        carry   = '0;
        add_sum = '0;
        for (int i = 0; i < WIDTH; i++) begin
            add_sum[i]   = acc[i] ^ Operand[i] ^ carry[i];
            carry[i+1]   = (acc[i] & Operand[i]) | (carry[i] & (acc[i] ^ Operand[i]));
        end
    end

    // Abort gates ready so a simultaneous operand is never counted.
    assign InReady  = (state != DONE) & ~Abort;
    assign accept   = InValid & InReady;
    assign OutValid = (state == DONE);
    assign Sum      = acc;
    assign OpCount  = cnt;

    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        cnt_nx   = cnt;
        if (Abort) begin
            state_nx = IDLE;
            acc_nx   = '0;
            cnt_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc_nx   = Operand;
                        cnt_nx   = CW'(1);
                        state_nx = ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc_nx = add_sum;
                        cnt_nx = cnt + CW'(1);
                        if (cnt + CW'(1) == CW'(NOPS)) begin
                            state_nx = DONE;
                        end
                    end
                end
                DONE: begin
                    // Acc is kept so Sum still shows the last result in IDLE.
                    if (OutReady) begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            cnt   <= cnt_nx;
        end
    end

`ifdef SHA256_ACC_CARRY_COUNT_EN
    localparam int CCW = $clog2(NOPS);

    logic [CCW-1:0] cc, cc_nx;

    always_comb begin
        cc_nx = cc;
        if (Abort) begin
            cc_nx = '0;
        end else if (accept && state == IDLE) begin
            cc_nx = '0;
        end else if (accept && state == ACCUM && carry[WIDTH]) begin
            cc_nx = cc + CCW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc <= '0;
        end else begin
            cc <= cc_nx;
        end
    end

    assign CarryCount = cc;
`endif

endmodule

// File: tb/tb_sha256_word_accumulator.sv
// ---------------------------------------------------------------------------
// tb_sha256_word_accumulator
//
// Self-checking bench for sha256_word_accumulator (WIDTH=32, NOPS=5).
// Reference model: the operands accepted into the current sum are kept in a
// queue. The expected Sum is their plain 64-bit total mod 2^32. The expected
// carry count is total >> 32. A compare process checks every output on every
// falling edge. Directed scenarios add literal expectations that pin the model.
// ---------------------------------------------------------------------------
module tb_sha256_word_accumulator;

  localparam int WIDTH = 32;
  localparam int NOPS  = 5;
  localparam int CW    = $clog2(NOPS + 1);

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             InValid = 1'b0;
  logic             Abort = 1'b0;
  logic             OutReady = 1'b0;
  logic [WIDTH-1:0] Operand = '0;
  logic             InReady;
  logic             OutValid;
  logic [WIDTH-1:0] Sum;
  logic [CW-1:0]    OpCount;
`ifdef SHA256_ACC_CARRY_COUNT_EN
  logic [$clog2(NOPS)-1:0] CarryCount;
`endif

  always #5 clk = ~clk;

  sha256_word_accumulator #(.WIDTH(WIDTH), .NOPS(NOPS)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .InValid(InValid),
    .InReady(InReady),
    .Operand(Operand),
    .Abort(Abort),
    .OutValid(OutValid),
    .OutReady(OutReady),
    .Sum(Sum),
    .OpCount(OpCount)
`ifdef SHA256_ACC_CARRY_COUNT_EN
    ,
    .CarryCount(CarryCount)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (act === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [WIDTH-1:0] exp_q[$];   // operands accepted into the current sum
  bit               m_done;     // sum complete, waiting for the downstream stage
  logic [WIDTH-1:0] m_hold;     // Sum value when no sum is in progress
  logic [63:0]      m_hold_c;   // carry count when no sum is in progress

  function automatic logic [63:0] m_total();
    logic [63:0] t;
    t = '0;
    foreach (exp_q[i]) t = t + 64'(exp_q[i]);
    return t;
  endfunction

  function automatic logic [WIDTH-1:0] m_sum();
    logic [63:0] t;
    t = m_total();
    return (exp_q.size() != 0) ? t[WIDTH-1:0] : m_hold;
  endfunction

  function automatic logic [63:0] m_carries();
    return (exp_q.size() != 0) ? (m_total() >> WIDTH) : m_hold_c;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_done   = 1'b0;
      m_hold   = '0;
      m_hold_c = '0;
    end
    chk("cyc_outvalid", 64'(OutValid), 64'(m_done));
    chk("cyc_inready", 64'(InReady), 64'(!m_done && !Abort));
    chk("cyc_opcount", 64'(OpCount), 64'(exp_q.size()));
    chk("cyc_sum", 64'(Sum), 64'(m_sum()));
`ifdef SHA256_ACC_CARRY_COUNT_EN
    chk("cyc_carrycount", 64'(CarryCount), m_carries());
`endif
    // Advance the model with the inputs the next rising edge will sample.
    if (rst_n) begin
      if (Abort) begin
        exp_q.delete();
        m_done   = 1'b0;
        m_hold   = '0;
        m_hold_c = '0;
      end else if (m_done) begin
        if (OutReady) begin
          m_hold   = m_sum();
          m_hold_c = m_carries();
          exp_q.delete();
          m_done   = 1'b0;
        end
      end else if (InValid) begin
        exp_q.push_back(Operand);
        if (exp_q.size() == NOPS) m_done = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic feed(input logic [WIDTH-1:0] v, input int gap);
    int budget;
    budget = 50;
    while (!InReady && budget > 0) begin
      @(negedge clk);
      budget = budget - 1;
    end
    if (budget == 0) chk("feed_ready_timeout", 64'(InReady), 64'd1);
    InValid = 1'b1;
    Operand = v;
    @(posedge clk);
    #1;
    InValid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic take();
    OutReady = 1'b1;
    @(posedge clk);
    #1;
    OutReady = 1'b0;
  endtask

  // ---------------- directed + random stimulus ----------------
  logic [WIDTH-1:0] stall_ops [5];

  initial begin
    stall_ops[0] = 32'h6A09E667;
    stall_ops[1] = 32'hBB67AE85;
    stall_ops[2] = 32'h3C6EF372;
    stall_ops[3] = 32'hA54FF53A;
    stall_ops[4] = 32'h510E527F;

    rst_n = 1'b0;
    #1;
    chk("reset_sum", 64'(Sum), 64'd0);
    chk("reset_outvalid", 64'(OutValid), 64'd0);
    chk("reset_inready", 64'(InReady), 64'd1);
    chk("reset_opcount", 64'(OpCount), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic sum, back to back: OutValid in the sixth cycle.
    for (int i = 1; i <= 5; i++) feed(WIDTH'(i), 0);
    @(negedge clk);
    chk("basic_outvalid", 64'(OutValid), 64'd1);
    chk("basic_sum", 64'(Sum), 64'd15);
    chk("basic_opcount", 64'(OpCount), 64'd5);
`ifdef SHA256_ACC_CARRY_COUNT_EN
    chk("basic_carry", 64'(CarryCount), 64'd0);
`endif
    take();
    @(negedge clk);
    chk("basic_idle_after_take", 64'(OutValid), 64'd0);

    // Wrap-around.
    for (int i = 0; i < 5; i++) feed(32'hFFFFFFFF, 0);
    @(negedge clk);
    chk("wrap_sum", 64'(Sum), 64'hFFFFFFFB);
`ifdef SHA256_ACC_CARRY_COUNT_EN
    chk("wrap_carry", 64'(CarryCount), 64'd4);
`endif
    take();

    // Stalls on InValid, then ten cycles of backpressure.
    // 0x583ED017 is the exact mod-2^32 sum of these five words.
    for (int i = 0; i < 5; i++) feed(stall_ops[i], (i < 4) ? 2 : 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_sum", 64'(Sum), 64'h583ED017);
      chk("stall_inready", 64'(InReady), 64'd0);
    end
    take();
    @(negedge clk);
    chk("stall_idle_after_take", 64'(OutValid), 64'd0);
    chk("stall_opcount_cleared", 64'(OpCount), 64'd0);

    // Abort together with InValid after three accepts.
    for (int i = 0; i < 3; i++) feed($urandom, 0);
    InValid = 1'b1;
    Abort   = 1'b1;
    Operand = $urandom;
    @(posedge clk);
    #1;
    InValid = 1'b0;
    Abort   = 1'b0;
    @(negedge clk);
    chk("abort_opcount", 64'(OpCount), 64'd0);
    chk("abort_sum", 64'(Sum), 64'd0);
    for (int i = 0; i < 5; i++) feed(32'd7, 0);
    @(negedge clk);
    chk("abort_then_sum", 64'(Sum), 64'd35);
    take();

    // Abort in DONE together with OutReady.
    for (int i = 0; i < 5; i++) feed($urandom, 0);
    Abort    = 1'b1;
    OutReady = 1'b1;
    @(posedge clk);
    #1;
    Abort    = 1'b0;
    OutReady = 1'b0;
    @(negedge clk);
    chk("done_abort_outvalid", 64'(OutValid), 64'd0);
    chk("done_abort_sum", 64'(Sum), 64'd0);

    // Asynchronous reset between edges during ACCUM.
    feed($urandom, 0);
    feed($urandom, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_outvalid", 64'(OutValid), 64'd0);
    chk("async_sum", 64'(Sum), 64'd0);
    chk("async_opcount", 64'(OpCount), 64'd0);
    chk("async_inready", 64'(InReady), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) feed(WIDTH'(i), 0);
    @(negedge clk);
    chk("async_after_sum", 64'(Sum), 64'd15);
    take();

    // Randomized traffic, checked every cycle by the model.
    repeat (600) begin
      InValid  = ($urandom_range(0, 2) != 0);
      Operand  = $urandom;
      OutReady = ($urandom_range(0, 2) != 0);
      Abort    = ($urandom_range(0, 24) == 0);
      @(posedge clk);
      #1;
    end
    InValid  = 1'b0;
    OutReady = 1'b0;
    Abort    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
